uart_tx_arb: RTL and testbench

Packet-level round-robin arbiter and sequencer that shares one UART transmitter among N byte-stream requesters. It grants one channel at a time and optionally prefixes a channel-ID header byte. It feeds bytes to the transmitter with a single-cycle start pulse and holds the grant until that channel's last byte, or until an idle timeout. It sits between per-source byte producers (debug, logger, CPU mailbox) and the shared uart_tx.

---
 rtl/uart_tx_arb_pkg.sv | 27 ++
 rtl/uart_tx_arb_rr_arbiter.sv | 32 +++
 rtl/uart_tx_arb.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its round-robin picker.
package uart_tx_arb_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] HDR_BASE_DEFAULT = 8'h80;

    typedef enum logic [2:0] {
        ST_ARB      = 3'd0,
        ST_HDR      = 3'd1,
        ST_GET      = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_PULSE    = 3'd4,
        ST_WAIT_ACK = 3'd5
    } state_e;

    // Byte latched for transmission plus its packet-context flags
    typedef struct packed {
        logic              is_hdr;
        logic              last;
        logic [BYTE_W-1:0] data;
    } tx_byte_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Combinational round-robin picker: first request found searching upward from ptr+1 modulo N.
module rr_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          any_o,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic [IW-1:0] cand;

    always_comb begin
        any_o     = 1'b0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                any_o           = 1'b1;
                gnt_idx_o       = cand;
                gnt_oh_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin sharing of one UART transmitter among N byte-stream sources,
// with optional channel-ID header and idle-timeout release of the lock.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned      N        = 4,
    parameter bit               HDR_EN   = 1'b1,
    parameter logic [BYTE_W-1:0] HDR_BASE = HDR_BASE_DEFAULT,
    parameter int unsigned      TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in_valid,
    output logic [N-1:0]        in_ready,
    input  logic [BYTE_W*N-1:0] in_data,
    input  logic [N-1:0]        in_last,
    output logic                out_valid,
    output logic [BYTE_W-1:0]   out_data,
    input  logic                out_ready,
    output logic [N-1:0]        grant,
    output logic                busy
);

    localparam int unsigned IW = idx_w(N);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e              state_q;
    logic [IW-1:0]       owner_q;
    logic [IW-1:0]       ptr_q;
    logic [N-1:0]        grant_q;
    tx_byte_t            cur_q;
    logic [TW-1:0]       tcnt_q;
    logic                out_valid_q;
    logic [BYTE_W-1:0]   out_data_q;

    logic                arb_any;
    logic [N-1:0]        arb_oh;
    logic [IW-1:0]       arb_idx;
    logic                own_valid;
    logic                own_last;
    logic [BYTE_W-1:0]   own_data;

    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .req_i     (in_valid),
        .ptr_i     (ptr_q),
        .any_o     (arb_any),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    // Owner's lane selection; only the owner is ever offered in_ready, and only in GET
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        in_ready  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (owner_q == IW'(i)) begin
                own_valid = in_valid[i];
                own_last  = in_last[i];
                own_data  = in_data[i*BYTE_W +: BYTE_W];
                if (state_q == ST_GET) begin
                    in_ready[i] = in_valid[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            owner_q     <= '0;
            ptr_q       <= IW'(N - 1);
            grant_q     <= '0;
            cur_q       <= '0;
            tcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (arb_any) begin
                        owner_q <= arb_idx;
                        grant_q <= arb_oh;
                        ptr_q   <= arb_idx;
                        tcnt_q  <= '0;
                        state_q <= HDR_EN ? ST_HDR : ST_GET;
                    end
                end
                ST_HDR: begin
                    cur_q   <= '{is_hdr: 1'b1, last: 1'b0, data: HDR_BASE + BYTE_W'(owner_q)};
                    state_q <= ST_WAIT_RDY;
                end
                ST_GET: begin
                    if (own_valid) begin
                        cur_q   <= '{is_hdr: 1'b0, last: own_last, data: own_data};
                        tcnt_q  <= '0;
                        state_q <= ST_WAIT_RDY;
                    end else if (TIMEOUT != 0 && tcnt_q == TW'(TIMEOUT - 1)) begin
                        grant_q <= '0;
                        state_q <= ST_ARB;
                    end else begin
                        tcnt_q  <= tcnt_q + TW'(1);
                    end
                end
                ST_WAIT_RDY: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= cur_q.data;
                        state_q     <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // Transmitter has taken the byte once it reports not-idle
                    if (!out_ready) begin
                        tcnt_q <= '0;
                        if (!cur_q.is_hdr && cur_q.last) begin
                            grant_q <= '0;
                            state_q <= ST_ARB;
                        end else begin
                            state_q <= ST_GET;
                        end
                    end
                end
                default: begin
                    state_q <= ST_ARB;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_ARB);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboarded bench for uart_tx_arb: per-channel source queues, transmitter model, per-scenario tasks.
module tb_uart_tx_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  in_valid1, in_ready1, in_last1, grant1;
    logic [31:0] in_data1;
    logic        out_valid1, out_ready1, busy1;
    logic [7:0]  out_data1;
    logic [1:0]  in_valid2, in_ready2, in_last2, grant2;
    logic [15:0] in_data2;
    logic        out_valid2, out_ready2, busy2;
    logic [7:0]  out_data2;

    uart_tx_arb #(.N(4), .HDR_EN(1'b1), .HDR_BASE(8'h80), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
        .grant(grant1), .busy(busy1)
    );

    uart_tx_arb #(.N(2), .HDR_EN(1'b0), .HDR_BASE(8'h80), .TIMEOUT(0)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
        .grant(grant2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;
    int tx_hold = 4;
    int pulses2 = 0;

    logic [8:0]  src1_q [4][$];
    logic [8:0]  src2_q [2][$];
    logic [11:0] exp1_q [$];
    logic [9:0]  exp2_q [$];
    logic [3:0]  took1;
    logic [1:0]  took2;

    // Source model: head of each channel queue is presented until a handshake is seen
    initial begin
        in_valid1 = '0; in_last1 = '0; in_data1 = '0; took1 = '0;
        in_valid2 = '0; in_last2 = '0; in_data2 = '0; took2 = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (took1[c] && src1_q[c].size() > 0) void'(src1_q[c].pop_front());
                if (src1_q[c].size() > 0) begin
                    in_valid1[c] = 1'b1;
                    in_last1[c]  = src1_q[c][0][8];
                    in_data1[8*c +: 8] = src1_q[c][0][7:0];
                end else begin
                    in_valid1[c] = 1'b0;
                    in_last1[c]  = 1'b0;
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (took2[c] && src2_q[c].size() > 0) void'(src2_q[c].pop_front());
                if (src2_q[c].size() > 0) begin
                    in_valid2[c] = 1'b1;
                    in_last2[c]  = src2_q[c][0][8];
                    in_data2[8*c +: 8] = src2_q[c][0][7:0];
                end else begin
                    in_valid2[c] = 1'b0;
                    in_last2[c]  = 1'b0;
                end
            end
            #1;
            took1 = in_valid1 & in_ready1 & {4{~rst}};
            took2 = in_valid2 & in_ready2 & {2{~rst}};
        end
    end

    // Transmitter model and output scoreboard: goes busy for tx_hold cycles after each pulse
    int hold1 = 0, hold2 = 0;
    bit prev_ov1 = 1'b0, prev_ov2 = 1'b0;
    logic [11:0] e1;
    logic [9:0]  e2;
    initial begin
        out_ready1 = 1'b1;
        out_ready2 = 1'b1;
        forever begin
            @(negedge clk);
            if (out_valid1 === 1'b1) begin
                checks++;
                if (prev_ov1) begin errors++; $display("FAIL pulse_width1: out_valid high 2+ cycles, required 1"); end
                checks++;
                if (out_ready1 !== 1'b1) begin errors++; $display("FAIL tx_overrun1: pulse while out_ready=%b, required 1", out_ready1); end
                checks++;
                if (exp1_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_pulse1: got grant=%b data=%h, required no pulse", grant1, out_data1);
                end else begin
                    e1 = exp1_q.pop_front();
                    if ({grant1, out_data1} !== e1) begin
                        errors++; $display("FAIL pulse1: got grant=%b data=%h, required grant=%b data=%h", grant1, out_data1, e1[11:8], e1[7:0]);
                    end
                end
                out_ready1 = 1'b0;
                hold1 = tx_hold;
            end else if (hold1 > 0) begin
                hold1--;
                if (hold1 == 0) out_ready1 = 1'b1;
            end
            prev_ov1 = (out_valid1 === 1'b1);

            if (out_valid2 === 1'b1) begin
                checks++;
                if (prev_ov2) begin errors++; $display("FAIL pulse_width2: out_valid high 2+ cycles, required 1"); end
                checks++;
                if (exp2_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_pulse2: got grant=%b data=%h, required no pulse", grant2, out_data2);
                end else begin
                    e2 = exp2_q.pop_front();
                    if ({grant2, out_data2} !== e2) begin
                        errors++; $display("FAIL pulse2: got grant=%b data=%h, required grant=%b data=%h", grant2, out_data2, e2[9:8], e2[7:0]);
                    end
                end
                out_ready2 = 1'b0;
                hold2 = tx_hold;
                pulses2++;
            end else if (hold2 > 0) begin
                hold2--;
                if (hold2 == 0) out_ready2 = 1'b1;
            end
            prev_ov2 = (out_valid2 === 1'b1);
        end
    end

    task automatic clear_queues();
        for (int c = 0; c < 4; c++) src1_q[c].delete();
        for (int c = 0; c < 2; c++) src2_q[c].delete();
        exp1_q.delete();
        exp2_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        clear_queues();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
    endtask

    task automatic wait_done1(input int budget, output bit ok, output int rdy_cycles);
        ok = 1'b0;
        rdy_cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (|in_ready1) rdy_cycles++;
            if (exp1_q.size() == 0 && busy1 === 1'b0 && src1_q[0].size() == 0 && src1_q[1].size() == 0 &&
                src1_q[2].size() == 0 && src1_q[3].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_exp1(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (exp1_q.size() == n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid1); end
        checks++; if (out_data1 !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h, required 00", out_data1); end
        checks++; if (in_ready1 !== 4'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0000", in_ready1); end
        checks++; if (grant1 !== 4'b0) begin errors++; $display("FAIL rst_grant: got %b, required 0000", grant1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy1); end
        checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL rst_out_valid2: got %b, required 0", out_valid2); end
        checks++; if (out_data2 !== 8'h00) begin errors++; $display("FAIL rst_out_data2: got %h, required 00", out_data2); end
        checks++; if (grant2 !== 2'b0) begin errors++; $display("FAIL rst_grant2: got %b, required 00", grant2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy2: got %b, required 0", busy2); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok; int rc;
        do_reset();
        src1_q[1].push_back({1'b0, 8'h41});
        src1_q[1].push_back({1'b1, 8'h42});
        exp1_q.push_back({4'b0010, 8'h81});
        exp1_q.push_back({4'b0010, 8'h41});
        exp1_q.push_back({4'b0010, 8'h42});
        wait_done1(500, ok, rc);
        checks++; if (!ok) begin errors++; $display("FAIL single_done: %0d pulses outstanding, required 0", exp1_q.size()); end
        checks++; if (grant1 !== 4'b0) begin errors++; $display("FAIL single_release: grant=%b, required 0000", grant1); end
        checks++; if (out_data1 !== 8'h42) begin errors++; $display("FAIL single_hold: out_data=%h, required 42", out_data1); end
    endtask

    task automatic test_rr_lock();
        bit ok; int rc;
        do_reset();
        src1_q[0].push_back({1'b0, 8'hA0});
        src1_q[0].push_back({1'b1, 8'hA1});
        src1_q[0].push_back({1'b0, 8'hB0});
        src1_q[0].push_back({1'b1, 8'hB1});
        src1_q[2].push_back({1'b0, 8'hC0});
        src1_q[2].push_back({1'b1, 8'hC1});
        exp1_q.push_back({4'b0001, 8'h80}); exp1_q.push_back({4'b0001, 8'hA0}); exp1_q.push_back({4'b0001, 8'hA1});
        exp1_q.push_back({4'b0100, 8'h82}); exp1_q.push_back({4'b0100, 8'hC0}); exp1_q.push_back({4'b0100, 8'hC1});
        exp1_q.push_back({4'b0001, 8'h80}); exp1_q.push_back({4'b0001, 8'hB0}); exp1_q.push_back({4'b0001, 8'hB1});
        wait_done1(1000, ok, rc);
        checks++; if (!ok) begin errors++; $display("FAIL rr_done: %0d pulses outstanding, required 0", exp1_q.size()); end
    endtask

    task automatic test_timeout();
        bit ok; int rc; int k;
        do_reset();
        src1_q[1].push_back({1'b0, 8'h55});
        src1_q[3].push_back({1'b1, 8'h33});
        exp1_q.push_back({4'b0010, 8'h81}); exp1_q.push_back({4'b0010, 8'h55});
        exp1_q.push_back({4'b1000, 8'h83}); exp1_q.push_back({4'b1000, 8'h33});
        wait_exp1(2, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_first: %0d pulses outstanding, required 2", exp1_q.size()); end
        k = 0;
        while (grant1 === 4'b0010 && k < 100) begin
            @(negedge clk); #2;
            k++;
        end
        checks++; if (k != 18) begin errors++; $display("FAIL timeout_cycles: grant held %0d cycles after pulse, required 18", k); end
        checks++; if (grant1 !== 4'b0) begin errors++; $display("FAIL timeout_drop: grant=%b, required 0000", grant1); end
        wait_done1(500, ok, rc);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_next: %0d pulses outstanding, required 0", exp1_q.size()); end
    endtask

    task automatic test_slow_tx();
        bit ok; int rc;
        do_reset();
        tx_hold = 50;
        src1_q[2].push_back({1'b0, 8'h11});
        src1_q[2].push_back({1'b1, 8'h22});
        exp1_q.push_back({4'b0100, 8'h82}); exp1_q.push_back({4'b0100, 8'h11}); exp1_q.push_back({4'b0100, 8'h22});
        wait_done1(2000, ok, rc);
        checks++; if (!ok) begin errors++; $display("FAIL slow_done: %0d pulses outstanding, required 0", exp1_q.size()); end
        checks++; if (rc != 2) begin errors++; $display("FAIL slow_in_ready: in_ready high %0d cycles, required 2", rc); end
        tx_hold = 4;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok; int rc;
        do_reset();
        src1_q[2].push_back({1'b0, 8'h21});
        src1_q[2].push_back({1'b1, 8'h22});
        exp1_q.push_back({4'b0100, 8'h82}); exp1_q.push_back({4'b0100, 8'h21}); exp1_q.push_back({4'b0100, 8'h22});
        wait_exp1(2, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_hdr: %0d pulses outstanding, required 2", exp1_q.size()); end
        @(negedge clk);
        rst = 1'b1;
        clear_queues();
        @(negedge clk); #1;
        checks++; if (grant1 !== 4'b0) begin errors++; $display("FAIL mid_grant: got %b, required 0000", grant1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", busy1); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b, required 0", out_valid1); end
        checks++; if (in_ready1 !== 4'b0) begin errors++; $display("FAIL mid_in_ready: got %b, required 0000", in_ready1); end
        rst = 1'b0;
        #1;
        src1_q[2].push_back({1'b1, 8'h2A});
        src1_q[0].push_back({1'b1, 8'h0A});
        exp1_q.push_back({4'b0001, 8'h80}); exp1_q.push_back({4'b0001, 8'h0A});
        exp1_q.push_back({4'b0100, 8'h82}); exp1_q.push_back({4'b0100, 8'h2A});
        wait_done1(1000, ok, rc);
        checks++; if (!ok) begin errors++; $display("FAIL mid_after: %0d pulses outstanding, required 0", exp1_q.size()); end
    endtask

    task automatic test_no_hdr();
        bit ok; int p0;
        do_reset();
        p0 = pulses2;
        for (int i = 0; i < 10; i++) begin
            src2_q[1].push_back({(i == 9) ? 1'b1 : 1'b0, 8'(8'h30 + i)});
            exp2_q.push_back({2'b10, 8'(8'h30 + i)});
        end
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #2;
            if (exp2_q.size() == 0 && busy2 === 1'b0 && src2_q[1].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL nohdr_done: %0d pulses outstanding, required 0", exp2_q.size()); end
        checks++; if (pulses2 - p0 != 10) begin errors++; $display("FAIL nohdr_count: got %0d pulses, required 10", pulses2 - p0); end
        checks++; if (grant2 !== 2'b0) begin errors++; $display("FAIL nohdr_release: grant=%b, required 00", grant2); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_rr_lock();
        test_timeout();
        test_slow_tx();
        test_reset_mid();
        test_no_hdr();
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
